// File: rtl/frame_sequencer_if.sv
// Memory-arbiter bus between the frame sequencer (master) and the arbiter (slave).
interface frame_sequencer_if #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned RC_W     = 7,
   parameter int unsigned WB_WORDS = 3,
   parameter int unsigned WI_W     = (WB_WORDS > 1) ? $clog2(WB_WORDS) : 1
);
   logic              mem_req;
   logic              mem_gnt;
   logic              mem_rd_wr;
   logic              tem_win;
   logic [RC_W-1:0]   mem_row;
   logic [RC_W-1:0]   mem_col;
   logic [DATA_W-1:0] write_data;
   logic [WI_W-1:0]   wr_index;

   modport master (
      output mem_req, mem_rd_wr, tem_win, mem_row, mem_col, write_data, wr_index,
      input  mem_gnt
   );

   modport slave (
      input  mem_req, mem_rd_wr, tem_win, mem_row, mem_col, write_data, wr_index,
      output mem_gnt
   );
endinterface

// File: rtl/frame_sequencer.sv
// Frame-level sequencer: template fetch, window fetch and granted result write-back
// for NUM_SETS sets, with template-reuse mode and synchronous abort.
module frame_sequencer #(
   parameter int unsigned NUM_SETS = 150,
   parameter int unsigned WB_WORDS = 3,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned RC_W     = 7,
   parameter int unsigned SET_W    = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
   parameter int unsigned WI_W     = (WB_WORDS > 1) ? $clog2(WB_WORDS) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       abort,
   input  logic                       reuse_tmpl,
   input  logic [RC_W-1:0]            tmpl_row,
   input  logic [RC_W-1:0]            tmpl_col,
   input  logic [RC_W-1:0]            win_row,
   input  logic [RC_W-1:0]            win_col,
   input  logic                       tmpl_done,
   input  logic                       win_done,
   input  logic [WB_WORDS*DATA_W-1:0] result_data,
   output logic                       tmpl_en,
   output logic                       win_en,
   output logic [SET_W-1:0]           set,
   output logic                       set_done,
   output logic                       busy,
   frame_sequencer_if.master          mem
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_TEMP = 3'd1;
   localparam logic [2:0] S_WIND = 3'd2;
   localparam logic [2:0] S_WRIT = 3'd3;
   localparam logic [2:0] S_NEXT = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   localparam logic [SET_W-1:0] LAST_SET  = SET_W'(NUM_SETS - 1);
   localparam logic [WI_W-1:0]  LAST_WORD = WI_W'(WB_WORDS - 1);

   logic [2:0]                        state_q, state_d;
   logic [SET_W-1:0]                  set_q, set_d;
   logic [WI_W-1:0]                   wr_idx_q, wr_idx_d;
   logic [WB_WORDS-1:0][DATA_W-1:0]   wb_buf_q, wb_buf_d;
   logic                              reuse_q, reuse_d;

   logic              tmpl_en_d, win_en_d, mem_req_d, mem_rd_wr_d, tem_win_d;
   logic              set_done_d, busy_d;
   logic [RC_W-1:0]   mem_row_d, mem_col_d;
   logic [DATA_W-1:0] write_data_d;

   // Next-state, counter and registered-output decode
   always_comb begin
      state_d  = state_q;
      set_d    = set_q;
      wr_idx_d = wr_idx_q;
      wb_buf_d = wb_buf_q;
      reuse_d  = reuse_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_TEMP;
               reuse_d  = reuse_tmpl;
               set_d    = '0;
               wr_idx_d = '0;
            end
         end
         S_TEMP: begin
            if (tmpl_done) state_d = S_WIND;
         end
         S_WIND: begin
            if (win_done) begin
               wb_buf_d = result_data;
               wr_idx_d = '0;
               state_d  = S_WRIT;
            end
         end
         S_WRIT: begin
            if (mem.mem_gnt) begin
               if (wr_idx_q == LAST_WORD) begin
                  wr_idx_d = '0;
                  state_d  = S_NEXT;
               end else begin
                  wr_idx_d = wr_idx_q + WI_W'(1);
               end
            end
         end
         S_NEXT: begin
            if (set_q == LAST_SET) begin
               state_d = S_DONE;
            end else begin
               set_d   = set_q + SET_W'(1);
               state_d = reuse_q ? S_WIND : S_TEMP;
            end
         end
         S_DONE: begin
            set_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Abort wins over any handshake seen in the same cycle
      if (abort && (state_q inside {S_TEMP, S_WIND, S_WRIT, S_NEXT})) begin
         state_d  = S_IDLE;
         set_d    = '0;
         wr_idx_d = '0;
         wb_buf_d = wb_buf_q;
         reuse_d  = reuse_q;
      end

      tmpl_en_d    = (state_d == S_TEMP);
      win_en_d     = (state_d == S_WIND);
      mem_rd_wr_d  = (state_d == S_WRIT);
      mem_req_d    = tmpl_en_d | win_en_d | mem_rd_wr_d;
      tem_win_d    = win_en_d;
      set_done_d   = (state_d == S_DONE);
      busy_d       = (state_d != S_IDLE);
      mem_row_d    = tmpl_en_d ? tmpl_row : (win_en_d ? win_row : '0);
      mem_col_d    = tmpl_en_d ? tmpl_col : (win_en_d ? win_col : '0);
      write_data_d = mem_rd_wr_d ? wb_buf_d[wr_idx_d] : '0;
   end

   // State, counters, buffer and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         set_q          <= '0;
         wr_idx_q       <= '0;
         wb_buf_q       <= '0;
         reuse_q        <= 1'b0;
         tmpl_en        <= 1'b0;
         win_en         <= 1'b0;
         set_done       <= 1'b0;
         busy           <= 1'b0;
         mem.mem_req    <= 1'b0;
         mem.mem_rd_wr  <= 1'b0;
         mem.tem_win    <= 1'b0;
         mem.mem_row    <= '0;
         mem.mem_col    <= '0;
         mem.write_data <= '0;
      end else begin
         state_q        <= state_d;
         set_q          <= set_d;
         wr_idx_q       <= wr_idx_d;
         wb_buf_q       <= wb_buf_d;
         reuse_q        <= reuse_d;
         tmpl_en        <= tmpl_en_d;
         win_en         <= win_en_d;
         set_done       <= set_done_d;
         busy           <= busy_d;
         mem.mem_req    <= mem_req_d;
         mem.mem_rd_wr  <= mem_rd_wr_d;
         mem.tem_win    <= tem_win_d;
         mem.mem_row    <= mem_row_d;
         mem.mem_col    <= mem_col_d;
         mem.write_data <= write_data_d;
      end
   end

   // Counters are registers; expose them directly
   assign set          = set_q;
   assign mem.wr_index = wr_idx_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Randomized scoreboard bench for frame_sequencer.
module tb_frame_sequencer;

   localparam int unsigned NUM_SETS = 3;
   localparam int unsigned WB_WORDS = 3;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned RC_W     = 7;
   localparam int unsigned SET_W    = 2;
   localparam int unsigned WI_W     = 2;
   localparam int          BOUND    = 2000;

   logic                       clk = 1'b0;
   logic                       rst;
   logic                       start, abort, reuse_tmpl;
   logic [RC_W-1:0]            tmpl_row, tmpl_col, win_row, win_col;
   logic                       tmpl_done, win_done;
   logic [WB_WORDS*DATA_W-1:0] result_data;
   logic                       tmpl_en, win_en, set_done, busy;
   logic [SET_W-1:0]           set;

   frame_sequencer_if #(.DATA_W(DATA_W), .RC_W(RC_W), .WB_WORDS(WB_WORDS)) mem_bus ();

   frame_sequencer #(
      .NUM_SETS(NUM_SETS), .WB_WORDS(WB_WORDS), .DATA_W(DATA_W), .RC_W(RC_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .reuse_tmpl(reuse_tmpl),
      .tmpl_row(tmpl_row), .tmpl_col(tmpl_col), .win_row(win_row), .win_col(win_col),
      .tmpl_done(tmpl_done), .win_done(win_done), .result_data(result_data),
      .tmpl_en(tmpl_en), .win_en(win_en), .set(set), .set_done(set_done), .busy(busy),
      .mem(mem_bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                set;
      int                idx;
      logic [DATA_W-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   mdl_set, sd_count, tmpl_starts;
   int   t_cnt, w_cnt, max_lat, stall_left;
   bit   stall_arm, abort_arm, abort_fired, glitch_arm, toggle_reuse, fixed_data;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: bound expired at %0t", name, $time);
   endtask

   // One cycle of stimulus: handler models, arbiter grants, abort/stall/glitch injection
   task automatic step();
      logic [DATA_W-1:0] w;
      @(posedge clk);
      #1;
      tmpl_done       = 1'b0;
      win_done        = 1'b0;
      abort           = 1'b0;
      start           = 1'b0;
      mem_bus.mem_gnt = ($urandom_range(0, 3) != 0);
      if (toggle_reuse) reuse_tmpl = 1'($urandom_range(0, 1));
      if (tmpl_en) begin
         if (t_cnt == 0) tmpl_done = 1'b1;
         else t_cnt--;
      end else begin
         t_cnt = $urandom_range(0, max_lat);
      end
      if (win_en) begin
         if (w_cnt == 0) begin
            win_done = 1'b1;
            for (int k = 0; k < WB_WORDS; k++) begin
               w = fixed_data ? DATA_W'(k + 10) : DATA_W'($urandom);
               result_data[k*DATA_W +: DATA_W] = w;
               exp_q.push_back('{mdl_set, k, w});
            end
            mdl_set++;
         end else begin
            w_cnt--;
         end
      end else begin
         w_cnt = $urandom_range(0, max_lat);
      end
      if (glitch_arm && win_en) begin
         start      = 1'b1;
         glitch_arm = 1'b0;
      end
      if (stall_arm && mem_bus.mem_rd_wr && mem_bus.wr_index == WI_W'(1)) begin
         if (stall_left > 0) begin
            mem_bus.mem_gnt = 1'b0;
            stall_left--;
         end else begin
            mem_bus.mem_gnt = 1'b1;
            stall_arm       = 1'b0;
         end
      end
      if (abort_arm && mem_bus.mem_rd_wr && set == SET_W'(1)) begin
         abort           = 1'b1;
         mem_bus.mem_gnt = 1'b1;
         abort_arm       = 1'b0;
         abort_fired     = 1'b1;
         exp_q.delete();
      end
   endtask

   task automatic launch(input bit reuse, input int lat, input bit fixed);
      step();
      tmpl_row   = RC_W'($urandom);
      tmpl_col   = RC_W'($urandom);
      win_row    = RC_W'($urandom);
      win_col    = RC_W'($urandom);
      mdl_set    = 0;
      tmpl_starts = 0;
      max_lat    = lat;
      fixed_data = fixed;
      start      = 1'b1;
      reuse_tmpl = reuse;
   endtask

   task automatic run_frame(input bit reuse, input bit stall, input bit glitch,
                            input bit toggle, input int lat, input bit fixed);
      int sd0;
      int cyc;
      sd0 = sd_count;
      launch(reuse, lat, fixed);
      stall_arm    = stall;
      stall_left   = 4;
      glitch_arm   = glitch;
      toggle_reuse = toggle;
      cyc = 0;
      while (sd_count == sd0 && cyc < BOUND) begin
         step();
         cyc++;
      end
      if (cyc >= BOUND) fail_now("frame_timeout");
      toggle_reuse = 1'b0;
      reuse_tmpl   = 1'b0;
      check("frame_words_left", 64'(exp_q.size()), 0);
      check("frame_set_count", 64'(mdl_set), NUM_SETS);
      check("frame_tmpl_fetches", 64'(tmpl_starts), reuse ? 1 : NUM_SETS);
      check("frame_set_done_pulses", 64'(sd_count - sd0), 1);
      check("frame_busy_end", busy, 0);
      check("frame_set_end", set, 0);
      if (stall) check("stall_consumed", 64'(stall_left), 0);
      stall_arm  = 1'b0;
      glitch_arm = 1'b0;
   endtask

   // Monitor: pops the scoreboard on every granted write and checks bus rules
   logic              prev_stall, prev_sd, prev_tmpl;
   logic [DATA_W-1:0] prev_wd;
   logic [WI_W-1:0]   prev_wi;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_stall = 1'b0;
         prev_sd    = 1'b0;
         prev_tmpl  = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_hold_data", mem_bus.write_data, prev_wd);
            check("stall_hold_index", mem_bus.wr_index, prev_wi);
            check("stall_hold_req", mem_bus.mem_req, 1);
         end
         if (mem_bus.mem_req && mem_bus.mem_rd_wr && mem_bus.mem_gnt && !abort) begin
            if (exp_q.size() == 0) begin
               fail_now("wb_unexpected_write");
            end else begin
               e = exp_q.pop_front();
               check("wb_data", mem_bus.write_data, e.data);
               check("wb_index", mem_bus.wr_index, e.idx);
               check("wb_set", set, e.set);
            end
         end
         if (tmpl_en) begin
            check("tmpl_row", mem_bus.mem_row, tmpl_row);
            check("tmpl_col", mem_bus.mem_col, tmpl_col);
            check("tmpl_req", {mem_bus.mem_req, mem_bus.mem_rd_wr, mem_bus.tem_win}, 3'b100);
         end else if (win_en) begin
            check("win_row", mem_bus.mem_row, win_row);
            check("win_col", mem_bus.mem_col, win_col);
            check("win_req", {mem_bus.mem_req, mem_bus.mem_rd_wr, mem_bus.tem_win}, 3'b101);
         end else begin
            check("addr_idle_zero", {mem_bus.mem_row, mem_bus.mem_col}, 0);
         end
         if (!mem_bus.mem_rd_wr) check("wdata_idle_zero", mem_bus.write_data, 0);
         if (prev_sd) begin
            check("busy_after_done", busy, 0);
            check("set_done_width", set_done, 0);
         end
         if (set_done) sd_count++;
         if (tmpl_en && !prev_tmpl) tmpl_starts++;
         prev_stall = mem_bus.mem_req && mem_bus.mem_rd_wr && !mem_bus.mem_gnt && !abort;
         prev_wd    = mem_bus.write_data;
         prev_wi    = mem_bus.wr_index;
         prev_sd    = set_done;
         prev_tmpl  = tmpl_en;
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"}, {tmpl_en, win_en, set_done, busy, mem_bus.mem_req,
                            mem_bus.mem_rd_wr, mem_bus.tem_win}, 0);
      check({tag, "_addr"}, {mem_bus.mem_row, mem_bus.mem_col}, 0);
      check({tag, "_wdata"}, mem_bus.write_data, 0);
      check({tag, "_cnt"}, {set, mem_bus.wr_index}, 0);
   endtask

   initial begin
      int sd0;
      int cyc;
      rst = 1'b1;
      {start, abort, reuse_tmpl, tmpl_done, win_done} = '0;
      {tmpl_row, tmpl_col, win_row, win_col} = '0;
      result_data     = '0;
      mem_bus.mem_gnt = 1'b0;
      sd_count = 0; tmpl_starts = 0; mdl_set = 0; t_cnt = 0; w_cnt = 0; max_lat = 0;
      {stall_arm, abort_arm, abort_fired, glitch_arm, toggle_reuse, fixed_data} = '0;
      stall_left = 0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;

      // Basic frame, single-cycle handlers, words A/B/C
      run_frame(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
      // Grant stall at wr_index 1
      run_frame(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      // Template reuse with reuse_tmpl wiggling mid-frame
      run_frame(1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0);

      // Abort during write-back of set 1 with a concurrent grant
      sd0 = sd_count;
      launch(1'b0, 0, 1'b0);
      abort_arm = 1'b1;
      cyc = 0;
      while (!abort_fired && cyc < BOUND) begin
         step();
         cyc++;
      end
      if (!abort_fired) fail_now("abort_trigger");
      abort_fired = 1'b0;
      abort_arm   = 1'b0;
      step();
      check_all_zero("abort");
      repeat (4) step();
      check("abort_no_set_done", 64'(sd_count - sd0), 0);
      check("abort_stays_idle", busy, 0);

      // Full frame after abort, with a stray start during WIND and reuse toggling
      run_frame(1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0);

      // Asynchronous reset in the middle of TEMP
      launch(1'b0, 3, 1'b0);
      cyc = 0;
      while (!tmpl_en && cyc < BOUND) begin
         step();
         cyc++;
      end
      if (!tmpl_en) fail_now("reset_wait_tmpl");
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("async_reset");
      step();
      step();
      rst = 1'b0;
      exp_q.delete();
      sd0 = sd_count;
      for (int i = 0; i < 5; i++) begin
         step();
         check("post_reset_idle", {busy, tmpl_en, mem_bus.mem_req}, 0);
      end
      check("post_reset_no_done", 64'(sd_count - sd0), 0);

      // Randomized frames
      for (int f = 0; f < 8; f++) begin
         run_frame(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
      end

      repeat (2) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
